addr_burst_gen: RTL
===================

# addr_burst_gen

Address burst generator for the DRAM DMA path. It accepts a burst command (start address and beat count) through a valid/ready handshake. It then emits one address per beat on a valid/ready output stream, advancing by a fixed stride with 32-bit wrap-around, and flags the last beat. It sits directly upstream of the DMA read/write address channel and drives the address-increment stage with successive addresses.

## Interface
- ADDR_W, 32, address width in bits
- CNT_W, 16, beat-count width in bits
- STRIDE, 4, byte increment between consecutive beat addresses (1..2^ADDR_W-1)

Ports:
- clk  in  1  sole clock, all logic rising-edge
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_addr  in  ADDR_W  start address of burst
- cmd_count  in  CNT_W  number of beats (0 allowed)
- addr_valid  out  1  addr_out holds a valid beat address
- addr_ready  in  1  downstream accepts addr_out
- addr_out  out  ADDR_W  current beat address
- addr_last  out  1  current beat is final beat of burst
- done  out  1  one-cycle pulse, burst complete

## Operation
- States: IDLE, RUN, FIN.
- IDLE:
  - cmd_ready=1, addr_valid=0.
  - cmd_valid&cmd_ready at an edge captures cmd_addr into the address register and cmd_count into the remaining counter.
  - If cmd_count≠0, go to RUN; if cmd_count=0, go to FIN (no beats emitted).
- RUN:
  - cmd_ready=0, addr_valid=1, addr_out=address register, addr_last=(remaining==1).
  - On each addr_valid&addr_ready edge: address ← (address+STRIDE) mod 2^ADDR_W, remaining ← remaining−1.
  - A handshake with addr_last=1 goes to FIN.
- FIN: done=1 for exactly that cycle, cmd_ready=0, addr_valid=0; next state IDLE.
- cmd_valid is ignored outside IDLE; commands are not queued.
- Arithmetic: the address adder is ADDR_W bits with carry discarded. 0xFFFF_FFFC+4 yields 0x0000_0000 and no error is flagged.
- Output stability: while addr_valid=1 and addr_ready=0, addr_out and addr_last hold constant.
- Maximum burst is 2^CNT_W−1 beats.

## Timing
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - cmd_ready=0, addr_valid=0, addr_out=0, addr_last=0, done=0.
  - cmd_ready rises at the first rising edge after rst_n deasserts.
- All outputs are registered or decoded directly from registered state; there is no combinational path from inputs to outputs.
- Command accepted at edge N: addr_valid=1 with addr_out=cmd_addr in cycle N+1.
- Throughput is one beat per cycle when addr_ready is held high.
- Final beat accepted at edge M: done=1 in cycle M+1, cmd_ready=1 in cycle M+2.
  - Minimum gap between bursts is 2 cycles.
- Zero-count command accepted at edge N: done=1 in cycle N+1, cmd_ready=1 in cycle N+2, addr_valid never asserted.
- Reset mid-burst: the burst is abandoned immediately, with no done pulse and no further addresses.

## Test plan
- Basic burst: cmd_addr=0x0000_1000, cmd_count=4, addr_ready=1 → addr_out 0x1000, 0x1004, 0x1008, 0x100C on consecutive cycles.
  - addr_last=1 only on 0x100C.
  - done pulses one cycle after it.
- Wrap: cmd_addr=0xFFFF_FFF8, cmd_count=3 → addr_out 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000, with addr_last on 0x0000_0000.
- Backpressure: cmd_addr=0x2000, cmd_count=2, addr_ready low for 5 cycles then toggling 1/0 → each address is held stable while not accepted.
  - Exactly 2 handshakes (0x2000, 0x2004) occur, and done follows the second.
- Zero count and ignored commands: cmd_count=0 → done next cycle, no addr_valid.
  - A second cmd_valid asserted during RUN of a 4-beat burst is not accepted; cmd_ready stays 0 until 2 cycles after the last beat.
- Reset mid-burst: rst_n low after 2 of 8 beats → all outputs 0 immediately, no done.
  - After release, cmd_ready=1 at the next edge and a new burst from 0x3000 runs correctly.
- Max count: cmd_count=0xFFFF, STRIDE=4 from 0x0 → exactly 65535 beats, last address 0x0003_FFF8 with addr_last=1.

Source files
------------

// File: rtl/addr_burst_gen_if.sv
// Burst command / beat address stream bundle between a DMA controller and addr_burst_gen.
// Latency: none, wires only.
// Backpressure: cmd_valid/cmd_ready on the command side, addr_valid/addr_ready on the beat side.
interface addr_burst_gen_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic [CNT_W-1:0]  cmd_count;
    logic              addr_valid;
    logic              addr_ready;
    logic [ADDR_W-1:0] addr_out;
    logic              addr_last;
    logic              done;

    // Command source / beat sink side (DMA controller, testbench)
    modport master (
        output cmd_valid, cmd_addr, cmd_count, addr_ready,
        input  cmd_ready, addr_valid, addr_out, addr_last, done
    );

    // Burst generator side
    modport slave (
        input  cmd_valid, cmd_addr, cmd_count, addr_ready,
        output cmd_ready, addr_valid, addr_out, addr_last, done
    );
endinterface

// File: rtl/addr_burst_gen.sv
// Address burst generator: one command in, one strided address per beat out, last-beat flag, done pulse.
// Latency: first beat the cycle after command acceptance; one beat per cycle with addr_ready high.
// Backpressure: addr_out/addr_last hold while addr_ready is low; cmd_ready only in IDLE (no queuing).
module addr_burst_gen #(
    parameter int                ADDR_W = 32,
    parameter int                CNT_W  = 16,
    parameter logic [ADDR_W-1:0] STRIDE = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    addr_burst_gen_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  rem_q;
    // Low only in the cycle(s) immediately following reset so cmd_ready comes up one edge after release.
    logic              armed;
    logic              cmd_fire;
    logic              beat_fire;
    logic              last_beat;

    assign cmd_fire  = (state == IDLE) && armed && bus.cmd_valid;
    assign beat_fire = (state == RUN) && bus.addr_ready;
    assign last_beat = (rem_q == CNT_W'(1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: zero-count commands skip straight to FIN
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cmd_fire) begin
                    state_nxt = (bus.cmd_count == '0) ? FIN : RUN;
                end
            end
            RUN: begin
                if (beat_fire && last_beat) begin
                    state_nxt = FIN;
                end
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Address / remaining-beat datapath; adder wraps modulo 2^ADDR_W by construction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            rem_q  <= '0;
            armed  <= 1'b0;
        end else begin
            armed <= 1'b1;
            if (cmd_fire) begin
                addr_q <= bus.cmd_addr;
                rem_q  <= bus.cmd_count;
            end else if (beat_fire) begin
                addr_q <= addr_q + STRIDE;
                rem_q  <= rem_q - CNT_W'(1);
            end
        end
    end

    // Outputs decoded from registered state only; nothing combinational from inputs
    always_comb begin
        bus.cmd_ready  = 1'b0;
        bus.addr_valid = 1'b0;
        bus.addr_last  = 1'b0;
        bus.done       = 1'b0;
        bus.addr_out   = addr_q;
        case (state)
            IDLE: bus.cmd_ready = armed;
            RUN: begin
                bus.addr_valid = 1'b1;
                bus.addr_last  = last_beat;
            end
            FIN:     bus.done = 1'b1;
            default: ;
        endcase
    end

endmodule
